// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment receive monitor: decode, frame assembly, debounce, publish
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic [3:0] ANODE,
  input  logic [6:0] SEG,
  output logic [3:0] DIGIT_3,
  output logic [3:0] DIGIT_2,
  output logic [3:0] DIGIT_1,
  output logic [3:0] DIGIT_0,
  output logic       FRAME_VALID,
  output logic       CHANGED,
  output logic       BLANK,
  output logic       ERR
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int FW = $clog2(STABLE_FRAMES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = '1;
  localparam logic [FW-1:0] STABLE_TGT  = FW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_TGT = TW'(TIMEOUT_CYCLES);

  logic [3:0]       anode_q;
  logic [SW-1:0]    settle_cnt;
  logic             sampled;
  logic [3:0]       seen;
  logic [3:0][3:0]  capture;
  logic [3:0][3:0]  prev_frame;
  logic [3:0][3:0]  digit_q;
  logic [FW-1:0]    stable_cnt;
  logic             published;
  logic [TW-1:0]    blank_cnt;
  logic             frame_valid_q;
  logic             changed_q;
  logic             blank_q;
  logic             err_q;

  logic [3:0]       seg_code;
  logic             one_low;
  logic [1:0]       sel;
  logic             multi_low;
  logic             anode_change;
  logic [SW-1:0]    settle_nxt;
  logic             do_sample;
  logic             frame_done;
  logic             frame_same;
  logic [FW-1:0]    stable_nxt;
  logic             published_nxt;
  logic             do_publish;
  logic [TW-1:0]    blank_nxt;
  logic             blank_hit;

  always_comb begin
    seg_code = 4'hE;
    case (SEG)
      7'h40: seg_code = 4'h0;
      7'h79: seg_code = 4'h1;
      7'h24: seg_code = 4'h2;
      7'h30: seg_code = 4'h3;
      7'h19: seg_code = 4'h4;
      7'h12: seg_code = 4'h5;
      7'h02: seg_code = 4'h6;
      7'h78: seg_code = 4'h7;
      7'h00: seg_code = 4'h8;
      7'h10: seg_code = 4'h9;
      7'h7F: seg_code = 4'hF;
      default: seg_code = 4'hE;
    endcase
  end

  always_comb begin
    one_low = 1'b1;
    sel     = 2'd0;
    case (ANODE)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign multi_low    = !one_low && (ANODE != 4'hF);
  assign anode_change = (ANODE != anode_q);

  // settle_nxt is the hold count after this edge, so a dwell of exactly
  // SETTLE_CYCLES edges samples on its last edge.
  assign settle_nxt = anode_change ? '0 :
                      (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
  assign do_sample  = one_low && (settle_nxt == SETTLE_LAST) && !sampled;

  assign frame_done    = (seen == 4'hF);
  assign frame_same    = (capture == prev_frame);
  assign stable_nxt    = !frame_same ? FW'(1) :
                         (stable_cnt >= STABLE_TGT) ? STABLE_TGT : stable_cnt + FW'(1);
  assign published_nxt = frame_same ? published : 1'b0;
  assign do_publish    = frame_done && (stable_nxt >= STABLE_TGT) && !published_nxt;

  assign blank_nxt = (ANODE != 4'hF) ? '0 :
                     (blank_cnt >= TIMEOUT_TGT) ? TIMEOUT_TGT : blank_cnt + TW'(1);
  assign blank_hit = (blank_nxt == TIMEOUT_TGT);

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      anode_q       <= 4'hF;
      settle_cnt    <= '0;
      sampled       <= 1'b0;
      seen          <= 4'h0;
      capture       <= {4{4'hF}};
      prev_frame    <= {4{4'hF}};
      digit_q       <= {4{4'hF}};
      stable_cnt    <= '0;
      published     <= 1'b0;
      blank_cnt     <= '0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
      blank_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      anode_q       <= ANODE;
      settle_cnt    <= settle_nxt;
      blank_cnt     <= blank_nxt;
      err_q         <= anode_change && multi_low;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;

      if (anode_change) begin
        sampled <= 1'b0;
      end

      if (frame_done) begin
        seen       <= 4'h0;
        stable_cnt <= stable_nxt;
        published  <= published_nxt;
        prev_frame <= capture;
        if (do_publish) begin
          digit_q       <= capture;
          frame_valid_q <= 1'b1;
          changed_q     <= (capture != digit_q);
          published     <= 1'b1;
        end
      end

      // Never coincides with frame_done: a new sample needs at least two edges of dwell.
      if (do_sample) begin
        capture[sel] <= seg_code;
        seen[sel]    <= 1'b1;
        sampled      <= 1'b1;
      end

      if (blank_hit) begin
        blank_q    <= 1'b1;
        seen       <= 4'h0;
        stable_cnt <= '0;
        published  <= 1'b0;
      end else if (ANODE != 4'hF) begin
        blank_q <= 1'b0;
      end
    end
  end

  assign DIGIT_3     = digit_q[3];
  assign DIGIT_2     = digit_q[2];
  assign DIGIT_1     = digit_q[1];
  assign DIGIT_0     = digit_q[0];
  assign FRAME_VALID = frame_valid_q;
  assign CHANGED     = changed_q;
  assign BLANK       = blank_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int SETTLE = 16;
  localparam int STABLE = 2;
  localparam int TMO    = 50;

  logic       MCLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] ANODE = 4'hF;
  logic [6:0] SEG = 7'h7F;
  logic [3:0] DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0;
  logic       FRAME_VALID, CHANGED, BLANK, ERR;

  seg_scan_decoder #(
    .SETTLE_CYCLES(SETTLE),
    .STABLE_FRAMES(STABLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .MCLK(MCLK),
    .RESET_N(RESET_N),
    .ANODE(ANODE),
    .SEG(SEG),
    .DIGIT_3(DIGIT_3),
    .DIGIT_2(DIGIT_2),
    .DIGIT_1(DIGIT_1),
    .DIGIT_0(DIGIT_0),
    .FRAME_VALID(FRAME_VALID),
    .CHANGED(CHANGED),
    .BLANK(BLANK),
    .ERR(ERR)
  );

  always #5 MCLK = ~MCLK;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int base;
  int base_err;

  logic [16:0] exp_q[$];
  logic [15:0] m_prev = 16'hFFFF;
  logic [15:0] m_dig = 16'hFFFF;
  int          m_stable = 0;
  bit          m_pub = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {DIGIT_3, DIGIT_2, DIGIT_1, DIGIT_0};
  endfunction

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    ANODE = a;
    SEG = s;
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic model_frame(input logic [15:0] codes);
    if (codes == m_prev) begin
      m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
    end else begin
      m_stable = 1;
      m_pub = 1'b0;
    end
    m_prev = codes;
    if (m_stable >= STABLE && !m_pub) begin
      exp_q.push_back({codes != m_dig, codes});
      m_dig = codes;
      m_pub = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_prev = 16'hFFFF;
    m_dig = 16'hFFFF;
    m_stable = 0;
    m_pub = 1'b0;
  endtask

  task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input logic [15:0] codes, input int dwell);
    if (dwell >= SETTLE) model_frame(codes);
    hold(4'b0111, s3, dwell);
    hold(4'b1011, s2, dwell);
    hold(4'b1101, s1, dwell);
    hold(4'b1110, s0, dwell);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_digits"}, digits(), 16'hFFFF);
    chk({tag, "_fv"}, FRAME_VALID, 1'b0);
    chk({tag, "_changed"}, CHANGED, 1'b0);
    chk({tag, "_blank"}, BLANK, 1'b0);
    chk({tag, "_err"}, ERR, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [16:0] e;
    fork
      forever begin
        @(negedge MCLK);
        if (ERR) err_cnt++;
        if (FRAME_VALID) begin
          fv_cnt++;
          chk("fv_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pub_digits", digits(), e[15:0]);
            chk("pub_changed", CHANGED, e[16]);
          end
        end
      end
    join_none

    repeat (3) @(posedge MCLK);
    #1;
    check_idle_outputs("rst");
    RESET_N = 1'b1;

    base = fv_cnt;
    repeat (3) scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 16'h1234, 100);
    chk("t1_fv_count", fv_cnt - base, 1);
    chk("t1_digits", digits(), 16'h1234);

    base = fv_cnt;
    scan_frame(7'h79, 7'h24, 7'h30, 7'h00, 16'h1238, 100);
    chk("t2_first8_no_fv", fv_cnt - base, 0);
    chk("t2_d0_still4", DIGIT_0, 4'h4);
    scan_frame(7'h79, 7'h24, 7'h30, 7'h00, 16'h1238, 100);
    chk("t2_fv_count", fv_cnt - base, 1);
    chk("t2_d0", DIGIT_0, 4'h8);

    base = fv_cnt;
    repeat (3) scan_frame(7'h12, 7'h02, 7'h78, 7'h10, 16'h5679, SETTLE - 1);
    chk("t3_short_no_fv", fv_cnt - base, 0);
    chk("t3_short_digits", digits(), 16'h1238);
    repeat (2) scan_frame(7'h12, 7'h02, 7'h78, 7'h10, 16'h5679, SETTLE);
    repeat (4) @(posedge MCLK);
    #1;
    chk("t3_fv_count", fv_cnt - base, 1);
    chk("t3_digits", digits(), 16'h5679);

    base = fv_cnt;
    base_err = err_cnt;
    hold(4'b0011, 7'h40, 5);
    chk("t4_err_pulses", err_cnt - base_err, 1);
    hold(4'hF, 7'h7F, TMO - 1);
    chk("t4_blank_early", BLANK, 1'b0);
    hold(4'hF, 7'h7F, 1);
    chk("t4_blank_set", BLANK, 1'b1);
    chk("t4_digits_kept", digits(), 16'h5679);
    m_stable = 0;
    m_pub = 1'b0;
    hold(4'b0111, 7'h79, 1);
    chk("t4_blank_clear", BLANK, 1'b0);
    chk("t4_no_fv", fv_cnt - base, 0);

    base = fv_cnt;
    repeat (2) scan_frame(7'h79, 7'h7F, 7'h55, 7'h00, 16'h1FE8, 100);
    chk("t5_fv_count", fv_cnt - base, 1);
    chk("t5_d2_blank", DIGIT_2, 4'hF);
    chk("t5_d1_unrec", DIGIT_1, 4'hE);

    hold(4'b0111, 7'h12, 100);
    hold(4'b1011, 7'h02, 100);
    RESET_N = 1'b0;
    hold(4'b1011, 7'h02, 1);
    check_idle_outputs("t6_rst");
    RESET_N = 1'b1;
    model_reset();
    base = fv_cnt;
    scan_frame(7'h19, 7'h30, 7'h24, 7'h79, 16'h4321, 100);
    chk("t6_first_no_fv", fv_cnt - base, 0);
    chk("t6_first_digits", digits(), 16'hFFFF);
    scan_frame(7'h19, 7'h30, 7'h24, 7'h79, 16'h4321, 100);
    chk("t6_fv_count", fv_cnt - base, 1);
    chk("t6_digits", digits(), 16'h4321);

    repeat (4) @(posedge MCLK);
    #1;
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
